// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM state type, coin bit indices and coin valuation for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {COLLECT, VEND, CHANGE, REFUND} vend_state_t;
  localparam int COIN_PENNY = 0;
  localparam int COIN_HAPENNY = 1;
  localparam int COIN_FARTH = 2;
  function automatic int coin_value(input logic [2:0] coin, input int penny_f, input int hapenny_f);
    return coin[COIN_PENNY] ? penny_f : coin[COIN_HAPENNY] ? hapenny_f : coin[COIN_FARTH] ? 1 : 0;
  endfunction
endpackage

// File: rtl/vend_ctrl_param_change_picker.sv
// change_picker: greedy largest-coin-not-above-credit selector; i_credit in, one-hot o_coin and its o_value out
module change_picker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int PENNY_F = 4,
  parameter int HAPENNY_F = 2
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [2:0]          o_coin,
  output logic [CREDIT_W-1:0] o_value
);
  localparam logic [CREDIT_W-1:0] P_VAL = CREDIT_W'(PENNY_F);
  localparam logic [CREDIT_W-1:0] H_VAL = CREDIT_W'(HAPENNY_F);
  localparam logic [CREDIT_W-1:0] F_VAL = CREDIT_W'(1);
  logic w_pen, w_hap, w_far;
  assign w_pen = i_credit >= P_VAL;
  assign w_hap = !w_pen && i_credit >= H_VAL;
  assign w_far = !w_pen && !w_hap && i_credit != '0;
  always_comb begin
    o_coin = '0;
    o_coin[COIN_PENNY] = w_pen;
    o_coin[COIN_HAPENNY] = w_hap;
    o_coin[COIN_FARTH] = w_far;
    o_value = w_pen ? P_VAL : w_hap ? H_VAL : w_far ? F_VAL : '0;
  end
endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised coin vending FSM; clk/res, coin_in/cancel/vend_ack/chg_ack in; credit/state_o/vend/chg_coin/coin_rej/busy out
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int PRICE_F = 5,
  parameter int CREDIT_W = 4,
  parameter int PENNY_F = 4,
  parameter int HAPENNY_F = 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic [2:0]          coin_in,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state_o,
  output logic                vend,
  output logic [2:0]          chg_coin,
  output logic                coin_rej,
  output logic                busy
);
  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] PRICE_W = SW'(PRICE_F);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_F);
  vend_state_t r_state, w_state_n;
  logic [CREDIT_W-1:0] r_credit, w_credit_n, w_chg_val;
  logic [SW-1:0] w_sum;
  logic [2:0] w_pick;
  logic r_rej, w_rej_n, w_coin_ok, w_cancel_ok, w_payout;
  assign w_coin_ok = $onehot(coin_in);
  assign w_cancel_ok = cancel && r_credit != '0;
  assign w_sum = {1'b0, r_credit} + SW'(coin_value(coin_in, PENNY_F, HAPENNY_F));
  assign w_payout = r_state == CHANGE || r_state == REFUND;
  change_picker #(.CREDIT_W(CREDIT_W), .PENNY_F(PENNY_F), .HAPENNY_F(HAPENNY_F)) u_pick (
    .i_credit(r_credit),
    .o_coin  (w_pick),
    .o_value (w_chg_val)
  );
  always_comb begin
    w_state_n = r_state;
    w_credit_n = r_credit;
    w_rej_n = |coin_in;
    case (r_state)
      COLLECT: begin
        if (w_cancel_ok) w_state_n = REFUND;
        else if (w_coin_ok) begin
          w_rej_n = 1'b0;
          w_credit_n = w_sum[CREDIT_W-1:0];
          w_state_n = w_sum >= PRICE_W ? VEND : COLLECT;
        end
      end
      VEND: begin
        if (vend_ack) begin
          w_credit_n = r_credit - PRICE_C;
          w_state_n = r_credit == PRICE_C ? COLLECT : CHANGE;
        end
      end
      default: begin
        if (chg_ack) begin
          w_credit_n = r_credit - w_chg_val;
          w_state_n = r_credit == w_chg_val ? COLLECT : r_state;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= COLLECT;
      r_credit <= '0;
      r_rej <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_credit <= w_credit_n;
      r_rej <= w_rej_n;
    end
  end
  assert property (@(posedge clk) disable iff (res) !(r_state == COLLECT && w_coin_ok && !w_cancel_ok && w_sum[CREDIT_W]));
  assign credit = r_credit;
  assign state_o = r_state;
  assign vend = r_state == VEND;
  assign chg_coin = w_payout ? w_pick : 3'b000;
  assign coin_rej = r_rej;
  assign busy = r_state != COLLECT;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: directed self-checking bench for vend_ctrl_param at PRICE_F=5, PENNY_F=4, HAPENNY_F=2
module tb_vend_ctrl_param;
  logic clk = 1'b0, res = 1'b1, cancel = 1'b0, vend_ack = 1'b0, chg_ack = 1'b0;
  logic [2:0] coin_in = 3'b000;
  logic [3:0] credit;
  logic [1:0] state_o;
  logic vend, coin_rej, busy;
  logic [2:0] chg_coin;
  int checks = 0, errors = 0;
  vend_ctrl_param #(.PRICE_F(5), .CREDIT_W(4), .PENNY_F(4), .HAPENNY_F(2)) dut (
    .clk(clk), .res(res), .coin_in(coin_in), .cancel(cancel), .vend_ack(vend_ack), .chg_ack(chg_ack),
    .credit(credit), .state_o(state_o), .vend(vend), .chg_coin(chg_coin), .coin_rej(coin_rej), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] c, input logic can, input logic va, input logic ca);
    coin_in = c; cancel = can; vend_ack = va; chg_ack = ca;
    tick();
    coin_in = 3'b000; cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;
  endtask
  task automatic test_reset();
    #12;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    checks++; if ({vend, chg_coin, coin_rej, busy} !== 6'b0) begin errors++; $display("FAIL reset_outs got=%b exp=000000", {vend, chg_coin, coin_rej, busy}); end
    res = 1'b0;
    tick();
  endtask
  task automatic test_exact();
    drive(3'b001, 0, 0, 0);
    checks++; if (credit !== 4'd4 || state_o !== 2'd0) begin errors++; $display("FAIL exact_penny credit=%0d state=%0d exp 4/0", credit, state_o); end
    drive(3'b100, 0, 0, 0);
    checks++; if (credit !== 4'd5 || state_o !== 2'd1 || vend !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL exact_vend credit=%0d state=%0d vend=%b busy=%b exp 5/1/1/1", credit, state_o, vend, busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (vend !== 1'b1 || credit !== 4'd5) begin errors++; $display("FAIL exact_hold%0d vend=%b credit=%0d exp 1/5", i, vend, credit); end
    end
    drive(3'b000, 0, 1, 0);
    checks++; if (credit !== 4'd0 || state_o !== 2'd0 || vend !== 1'b0 || chg_coin !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL exact_done credit=%0d state=%0d vend=%b chg=%b busy=%b exp 0/0/0/000/0", credit, state_o, vend, chg_coin, busy); end
  endtask
  task automatic test_overpay();
    drive(3'b001, 0, 0, 0);
    drive(3'b010, 0, 0, 0);
    checks++; if (credit !== 4'd6 || state_o !== 2'd1) begin errors++; $display("FAIL over_vend credit=%0d state=%0d exp 6/1", credit, state_o); end
    drive(3'b001, 1, 0, 1);
    checks++; if (coin_rej !== 1'b1 || credit !== 4'd6 || state_o !== 2'd1) begin errors++; $display("FAIL over_rej rej=%b credit=%0d state=%0d exp 1/6/1", coin_rej, credit, state_o); end
    drive(3'b000, 0, 1, 0);
    checks++; if (credit !== 4'd1 || state_o !== 2'd2 || chg_coin !== 3'b100 || vend !== 1'b0 || coin_rej !== 1'b0) begin errors++; $display("FAIL over_change credit=%0d state=%0d chg=%b vend=%b rej=%b exp 1/2/100/0/0", credit, state_o, chg_coin, vend, coin_rej); end
    drive(3'b000, 0, 1, 0);
    tick();
    checks++; if (chg_coin !== 3'b100 || credit !== 4'd1 || state_o !== 2'd2) begin errors++; $display("FAIL over_hold chg=%b credit=%0d state=%0d exp 100/1/2", chg_coin, credit, state_o); end
    drive(3'b000, 0, 0, 1);
    checks++; if (credit !== 4'd0 || state_o !== 2'd0 || chg_coin !== 3'b000) begin errors++; $display("FAIL over_done credit=%0d state=%0d chg=%b exp 0/0/000", credit, state_o, chg_coin); end
  endtask
  task automatic test_refund();
    drive(3'b010, 0, 0, 0);
    drive(3'b100, 0, 0, 0);
    checks++; if (credit !== 4'd3 || state_o !== 2'd0) begin errors++; $display("FAIL ref_credit credit=%0d state=%0d exp 3/0", credit, state_o); end
    drive(3'b000, 1, 0, 0);
    checks++; if (state_o !== 2'd3 || credit !== 4'd3 || chg_coin !== 3'b010 || vend !== 1'b0) begin errors++; $display("FAIL ref_enter state=%0d credit=%0d chg=%b vend=%b exp 3/3/010/0", state_o, credit, chg_coin, vend); end
    drive(3'b000, 0, 0, 1);
    checks++; if (state_o !== 2'd3 || credit !== 4'd1 || chg_coin !== 3'b100) begin errors++; $display("FAIL ref_second state=%0d credit=%0d chg=%b exp 3/1/100", state_o, credit, chg_coin); end
    drive(3'b000, 0, 0, 1);
    checks++; if (state_o !== 2'd0 || credit !== 4'd0 || chg_coin !== 3'b000 || vend !== 1'b0) begin errors++; $display("FAIL ref_done state=%0d credit=%0d chg=%b vend=%b exp 0/0/000/0", state_o, credit, chg_coin, vend); end
  endtask
  task automatic test_illegal();
    drive(3'b011, 0, 0, 0);
    checks++; if (coin_rej !== 1'b1 || credit !== 4'd0 || state_o !== 2'd0) begin errors++; $display("FAIL ill_multi rej=%b credit=%0d state=%0d exp 1/0/0", coin_rej, credit, state_o); end
    drive(3'b000, 1, 1, 1);
    checks++; if (coin_rej !== 1'b0 || credit !== 4'd0 || state_o !== 2'd0) begin errors++; $display("FAIL ill_spurious rej=%b credit=%0d state=%0d exp 0/0/0", coin_rej, credit, state_o); end
    drive(3'b001, 0, 0, 0);
    drive(3'b100, 0, 0, 0);
    drive(3'b100, 0, 0, 0);
    checks++; if (coin_rej !== 1'b1 || credit !== 4'd5 || state_o !== 2'd1) begin errors++; $display("FAIL ill_vendcoin rej=%b credit=%0d state=%0d exp 1/5/1", coin_rej, credit, state_o); end
    tick();
    checks++; if (coin_rej !== 1'b0) begin errors++; $display("FAIL ill_pulse rej=%b exp 0", coin_rej); end
    drive(3'b000, 0, 1, 0);
    checks++; if (state_o !== 2'd0 || credit !== 4'd0) begin errors++; $display("FAIL ill_done state=%0d credit=%0d exp 0/0", state_o, credit); end
  endtask
  task automatic test_simultaneous();
    drive(3'b010, 0, 0, 0);
    drive(3'b001, 1, 0, 0);
    checks++; if (state_o !== 2'd3 || credit !== 4'd2 || coin_rej !== 1'b1 || chg_coin !== 3'b010) begin errors++; $display("FAIL sim_cancel state=%0d credit=%0d rej=%b chg=%b exp 3/2/1/010", state_o, credit, coin_rej, chg_coin); end
    drive(3'b000, 0, 0, 1);
    checks++; if (state_o !== 2'd0 || credit !== 4'd0) begin errors++; $display("FAIL sim_done state=%0d credit=%0d exp 0/0", state_o, credit); end
  endtask
  task automatic test_async_reset();
    drive(3'b001, 0, 0, 0);
    drive(3'b001, 0, 0, 0);
    checks++; if (credit !== 4'd8 || state_o !== 2'd1) begin errors++; $display("FAIL ar_max credit=%0d state=%0d exp 8/1", credit, state_o); end
    drive(3'b000, 0, 1, 0);
    checks++; if (credit !== 4'd3 || state_o !== 2'd2 || chg_coin !== 3'b010) begin errors++; $display("FAIL ar_change credit=%0d state=%0d chg=%b exp 3/2/010", credit, state_o, chg_coin); end
    #2 res = 1'b1;
    #1;
    checks++; if (state_o !== 2'd0 || credit !== 4'd0 || chg_coin !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL ar_reset state=%0d credit=%0d chg=%b busy=%b exp 0/0/000/0", state_o, credit, chg_coin, busy); end
    #1 res = 1'b0;
    tick();
    checks++; if (state_o !== 2'd0 || credit !== 4'd0) begin errors++; $display("FAIL ar_after state=%0d credit=%0d exp 0/0", state_o, credit); end
  endtask
  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_refund();
    test_illegal();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised successor to the fixed 4-bit tomato vending FSM.
- Accumulates coin credit in farthings against a configurable price and asserts a vend request held until acknowledged.
- Pays out change, or a full refund on cancel, one coin at a time using greedy penny/ha'penny/farthing selection with a ready/ack handshake.
- Sits between the coin encoder/debouncers and the dispense/change-return actuators and display logic.

Parameters:
- PRICE_F, 5, item price in farthings; must be at least 1.
- CREDIT_W, 4, credit register width; must satisfy 2^CREDIT_W > PRICE_F+3.
- PENNY_F, 4, penny value in farthings.
- HAPENNY_F, 2, ha'penny value in farthings.

Ports:
- clk  in  1  single system clock; all registers on its rising edge.
- res  in  1  reset, asynchronous, active-high.
- coin_in  in  3  one-cycle coin pulses: [0] penny, [1] ha'penny, [2] farthing; already debounced and synchronised upstream.
- cancel  in  1  one-cycle refund request.
- vend_ack  in  1  dispenser has taken the item.
- chg_ack  in  1  change mechanism has ejected the presented coin.
- credit  out  CREDIT_W  current credit in farthings.
- state_o  out  2  FSM state code for LED/HEX display.
- vend  out  1  dispense request, level.
- chg_coin  out  3  one-hot coin to eject, same bit order as coin_in; level, held until chg_ack.
- coin_rej  out  1  one-cycle pulse: the coin was not accepted and must be returned mechanically.
- busy  out  1  high whenever the state is not COLLECT.

Behaviour:
- Reset values (asynchronous): state COLLECT, credit 0, vend 0, chg_coin 0, coin_rej 0, busy 0.
- Coin value: penny→PENNY_F, ha'penny→HAPENNY_F, farthing→1.
- Invalid coin: more than one coin_in bit high in the same cycle is rejected; coin_rej pulses next cycle and credit is unchanged.
- COLLECT (code 0):
  - A valid coin sampled at edge N sets credit = credit + value at edge N+1.
  - If the new sum ≥ PRICE_F, the state enters VEND at the same edge N+1; there is no extra idle cycle.
  - cancel with credit > 0 → REFUND.
  - cancel with credit = 0 is ignored.
  - cancel and a coin in the same cycle: cancel wins, the coin is rejected (coin_rej pulses).
- VEND (code 1):
  - vend = 1.
  - Any coin arriving is rejected (coin_rej pulses); cancel is ignored.
  - On an edge with vend_ack = 1: credit ← credit − PRICE_F, vend drops.
  - Next state is CHANGE if the remainder > 0, else COLLECT.
- CHANGE (code 2) and REFUND (code 3): identical payout logic; only the display code differs.
  - chg_coin selects the largest coin whose value ≤ credit (greedy) and is held stable while chg_ack = 0.
  - On an edge with chg_ack = 1: credit ← credit − coin value.
  - When credit reaches 0: return to COLLECT, chg_coin = 0 in the same cycle.
  - Coins are rejected; cancel is ignored.
- Maximum reachable credit is PRICE_F+3, so there is no credit overflow. A simulation assertion fires if the sum ever exceeds 2^CREDIT_W − 1.
- Spurious acks (vend_ack outside VEND, chg_ack outside CHANGE/REFUND) are ignored.
- Reset asserted mid-vend or mid-payout returns immediately to reset values; credit is lost by design.
- All outputs are registered or decoded from registered state only; there are no combinational paths from any input to any output except none.

Decomposition:
- Package vend_pkg holds:
  - typedef enum logic [1:0] {COLLECT, VEND, CHANGE, REFUND} vend_state_t
  - coin index constants COIN_PENNY=0, COIN_HAPENNY=1, COIN_FARTH=2
  - function coin_value()
- One sub-module, change_picker: purely combinational greedy selector taking credit and producing the one-hot chg_coin and its value.
- The FSM and credit datapath stay in vend_ctrl_param.

Test Plan (PRICE_F=5, PENNY_F=4, HAPENNY_F=2):
- Exact payment, penny then farthing: credit 4, then 5 with state VEND; vend held 3 cycles until vend_ack; then credit 0, state COLLECT, no chg_coin.
- Overpay, penny, ha'penny, penny: credit 4→6 → VEND; after vend_ack credit 1; CHANGE presents farthing (chg_coin=100) held until chg_ack; credit 0 → COLLECT.
- Refund, ha'penny, farthing, cancel: REFUND presents ha'penny (credit 3→1), then farthing (1→0) → COLLECT; vend never asserted.
- Illegal inputs: coin_in=011 in COLLECT → coin_rej pulse, credit unchanged; farthing during VEND → coin_rej pulse, credit unchanged.
- Simultaneous events: cancel together with a penny at credit 2 → REFUND with credit 2, coin_rej pulse.
- Asynchronous reset: res asserted mid-CHANGE with credit 3 → immediately state COLLECT, credit 0, chg_coin 0, independent of the clk edge.
